shiftfu_pipe: RTL

- Parametrised, pipelined shift/rotate functional unit for the out-of-order core.
- Successor to the single-cycle 8-bit shift FU: configurable data width, configurable pipeline depth, rotate modes, computed Z/N/C status, and an internal output buffer.
- Takes issued ops from the reservation station and delivers each result independently to the CDB and the ROB.
- Back-pressures issue through `busy`.

---
 rtl/shiftfu_pkg.sv | 38 +++
 rtl/shift_core.sv | 101 ++++++++++
 rtl/shiftfu_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/shiftfu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shiftfu_pkg
//  Description : Shared types and constants for the pipelined shift/rotate
//                functional unit (opcode enum, status bit indices, result
//                record carried through the pipeline and output buffer).
//  Options     : SHIFTFU_ROTATE_EN (consumed by shift_core)
//  Revision    : 1.0 - initial release
// ============================================================================
package shiftfu_pkg;

    // Upper bounds for the width-generic result record. Instances narrower
    // than these simply leave the upper bits at zero.
    localparam int unsigned MAX_XLEN    = 64;
    localparam int unsigned MAX_ROBID_W = 16;

    // Position of each computed status bit inside flags_out[2:0]
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;

    typedef enum logic [3:0] {
        SLL = 4'd0,
        SRL = 4'd1,
        SRA = 4'd2,
        ROL = 4'd3,
        ROR = 4'd4
    } shift_op_e;

    typedef struct packed {
        logic [MAX_ROBID_W-1:0] robid;
        logic [7:0]             wbs;
        logic [7:0]             flags;
        logic [MAX_XLEN-1:0]    value;
    } fu_result_t;

endpackage
`default_nettype wire

// File: rtl/shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : shift_core
//  Description : Purely combinational barrel shifter/rotator producing the
//                result and Z/N/C status for one op.
//  Options     : SHIFTFU_ROTATE_EN - when defined, ROL/ROR are implemented;
//                otherwise opcodes 3/4 behave as unused opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_core
    import shiftfu_pkg::*;
#(
    parameter int XLEN = 8
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic [2:0]      status
);

    localparam logic [XLEN-1:0] c_xlen = XLEN'(XLEN);

    // Shifts by XLEN or more are saturated separately, so the extended
    // shifters below only need to be correct for b < XLEN. The extra bit
    // catches the last bit shifted out (the carry).
    logic            w_big;
    logic [XLEN:0]   w_sll_ext;
    logic [XLEN:0]   w_srl_ext;
    logic [XLEN:0]   w_sra_ext;
    logic            w_carry;

    assign w_big     = (b >= c_xlen);
    assign w_sll_ext = {1'b0, a} << b;
    assign w_srl_ext = {a, 1'b0} >> b;
    assign w_sra_ext = $signed({a, 1'b0}) >>> b;

`ifdef SHIFTFU_ROTATE_EN
    localparam int LG = $clog2(XLEN);
    localparam logic [LG:0] c_xlen_rot = (LG+1)'(XLEN);

    // Rotates use b mod XLEN; a zero rotate leaves a unchanged with C=0
    logic [LG-1:0]   w_rot;
    logic [LG:0]     w_rot_inv;
    logic [XLEN-1:0] w_rol;
    logic [XLEN-1:0] w_ror;

    assign w_rot     = b[LG-1:0];
    assign w_rot_inv = c_xlen_rot - {1'b0, w_rot};
    assign w_rol     = (a << w_rot) | (a >> w_rot_inv);
    assign w_ror     = (a >> w_rot) | (a << w_rot_inv);
`endif

    // Select the result and carry for the opcode, then derive Z/N from it
    always_comb begin
        result  = '0;
        w_carry = 1'b0;
        case (op)
            SLL: begin
                if (!w_big) begin
                    result  = w_sll_ext[XLEN-1:0];
                    w_carry = w_sll_ext[XLEN];
                end
            end
            SRL: begin
                if (!w_big) begin
                    result  = w_srl_ext[XLEN:1];
                    w_carry = w_srl_ext[0];
                end
            end
            SRA: begin
                if (w_big) begin
                    result = {XLEN{a[XLEN-1]}};
                end else begin
                    result  = w_sra_ext[XLEN:1];
                    w_carry = w_sra_ext[0];
                end
            end
`ifdef SHIFTFU_ROTATE_EN
            ROL: begin
                result  = w_rol;
                w_carry = (w_rot != '0) & w_rol[0];
            end
            ROR: begin
                result  = w_ror;
                w_carry = (w_rot != '0) & w_ror[XLEN-1];
            end
`endif
            default: begin
                result  = '0;
                w_carry = 1'b0;
            end
        endcase
        status         = '0;
        status[FLAG_Z] = (result == '0);
        status[FLAG_N] = result[XLEN-1];
        status[FLAG_C] = w_carry;
    end

endmodule
`default_nettype wire

// File: rtl/shiftfu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shiftfu_pipe
//  Description : Pipelined shift/rotate FU. Wraps shift_core with STAGES of
//                latency, an in-order output buffer delivering each result
//                independently to the CDB and the ROB, and credit-based
//                issue back-pressure.
//  Options     : SHIFTFU_ROTATE_EN - enables ROL/ROR in shift_core.
//  Revision    : 1.0 - initial release
// ============================================================================
module shiftfu_pipe
    import shiftfu_pkg::*;
#(
    parameter int XLEN      = 8,
    parameter int ROBID_W   = 4,
    parameter int STAGES    = 1,
    parameter int OUT_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_transmit,
    input  logic [7:0]             operand,
    input  logic [1:0][XLEN-1:0]   depvals,
    input  logic [7:0]             wbs,
    input  logic [7:0]             flags,
    input  logic [ROBID_W-1:0]     robid,
    input  logic                   cdb_transmit,
    output logic                   cdb_transmit_out,
    output logic [ROBID_W-1:0]     cdb_id,
    output logic [XLEN-1:0]        cdb_val,
    input  logic                   rob_transmit,
    output logic [ROBID_W-1:0]     robid_out,
    output logic [7:0]             flags_out,
    output logic [7:0]             wbs_out,
    output logic [XLEN-1:0]        value_out,
    output logic                   rob_transmit_out,
    output logic                   busy
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [XLEN-1:0]  w_result;
    logic [2:0]       w_status;
    logic             w_accept;
    fu_result_t       w_issue;
    logic             w_wr_en;
    fu_result_t       w_wr_data;

    fu_result_t       r_fifo [OUT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_credit;   // ops in flight plus buffered entries
    logic             r_cdb_done;
    logic             r_rob_done;

    logic             w_head_vld;
    fu_result_t       w_head;
    logic             w_cdb_req;
    logic             w_rob_req;
    logic             w_cdb_ok;
    logic             w_rob_ok;
    logic             w_retire;
    logic             w_unused;

    shift_core #(.XLEN(XLEN)) u_core (
        .op     (operand[3:0]),
        .a      (depvals[1]),
        .b      (depvals[0]),
        .result (w_result),
        .status (w_status)
    );

    // Credits are taken at accept, so the buffer always has room on arrival
    assign busy     = (r_credit >= CNT_W'(OUT_DEPTH));
    assign w_accept = input_transmit & ~busy;

    // Pack the issued op into the record carried down the pipeline
    always_comb begin
        w_issue       = '0;
        w_issue.robid = MAX_ROBID_W'(robid);
        w_issue.wbs   = wbs;
        w_issue.flags = {flags[7:3], w_status};
        w_issue.value = MAX_XLEN'(w_result);
    end

    if (STAGES == 1) begin : g_direct
        assign w_wr_en   = w_accept;
        assign w_wr_data = w_issue;
    end else begin : g_pipe
        logic [STAGES-2:0] r_vld;
        fu_result_t        r_data [STAGES-1];

        // Valid bits advance one stage per cycle; reset drops in-flight ops
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_accept;
                for (int i = 1; i < STAGES - 1; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
        end

        // Payload follows its valid bit; no reset needed on data
        always_ff @(posedge clk) begin
            r_data[0] <= w_issue;
            for (int i = 1; i < STAGES - 1; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end

        assign w_wr_en   = r_vld[STAGES-2];
        assign w_wr_data = r_data[STAGES-2];
    end

    assign w_head_vld = (r_occ != '0);
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_cdb_req  = w_head_vld & ~r_cdb_done;
    assign w_rob_req  = w_head_vld & ~r_rob_done;
    // A sink is satisfied if already sent or granted now while requested
    assign w_cdb_ok   = r_cdb_done | (w_cdb_req & cdb_transmit);
    assign w_rob_ok   = r_rob_done | (w_rob_req & rob_transmit);
    assign w_retire   = w_head_vld & w_cdb_ok & w_rob_ok;

    // Buffer storage; stale entries are harmless since pointers gate them
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_fifo[r_wr_ptr] <= w_wr_data;
        end
    end

    // Pointers, occupancy, credits and per-head sent bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_credit   <= '0;
            r_cdb_done <= 1'b0;
            r_rob_done <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_retire) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_wr_en, w_retire})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            case ({w_accept, w_retire})
                2'b10:   r_credit <= r_credit + 1'b1;
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
            if (w_retire) begin
                r_cdb_done <= 1'b0;
                r_rob_done <= 1'b0;
            end else begin
                if (w_cdb_req & cdb_transmit) r_cdb_done <= 1'b1;
                if (w_rob_req & rob_transmit) r_rob_done <= 1'b1;
            end
        end
    end

    // Head drives the data ports; an empty buffer presents zeros
    always_comb begin
        cdb_transmit_out = w_cdb_req;
        rob_transmit_out = w_rob_req;
        cdb_id           = '0;
        cdb_val          = '0;
        robid_out        = '0;
        flags_out        = '0;
        wbs_out          = '0;
        value_out        = '0;
        if (w_head_vld) begin
            cdb_id    = w_head.robid[ROBID_W-1:0];
            cdb_val   = w_head.value[XLEN-1:0];
            robid_out = w_head.robid[ROBID_W-1:0];
            flags_out = w_head.flags;
            wbs_out   = w_head.wbs;
            value_out = w_head.value[XLEN-1:0];
        end
    end

    // Opcode high bits, overwritten flag bits and record padding are ignored
    assign w_unused = ^{operand[7:4], flags[2:0], w_head};

endmodule
`default_nettype wire
